iod_rx_eye_train_ctrl: RTL and testbench
========================================

// Module: iod_rx_eye_train_ctrl
// PURPOSE
//  Training controller for one generic RX IOD lane (DDRX, static-delay RX IOD with eye monitor).
//  Sweeps the input delay line and scores each tap from the EYE_MONITOR_EARLY/LATE flags.
//  Parks the delay at the centre of the widest clean window, then bit-slips until RX_DATA
//  matches the training word. Sits in fabric on FAB_CLK between the IOD wrapper and the
//  lane-level start/status logic.
// PARAMETERS
//  RX_WIDTH       4        deserialised word width (RX_DATA of IOD lane)
//  TAP_MAX        127      last delay tap swept (tap 0 = value after DELAY_LINE_LOAD); <=254
//  SETTLE_CYCLES  16       wait after any MOVE/LOAD/SLIP/CLEAR before sampling (>=1)
//  SAMPLE_CYCLES  32       cycles observed per tap / per pattern check (>=1)
//  MIN_EYE        4        minimum clean-window width (taps) for success
//  TRAIN_PATTERN  4'b1100  expected RX_DATA word after alignment (RX_WIDTH bits)
// PORTS
//  FAB_CLK                 in   1         lane fabric clock; all logic rising-edge
//  SYNC_RST_N              in   1         synchronous active-low reset
//  TRAIN_START             in   1         level/pulse; starts training from IDLE/DONE/ERR
//  EYE_MONITOR_EARLY       in   1         IOD eye-monitor early flag (sticky until clear)
//  EYE_MONITOR_LATE        in   1         IOD eye-monitor late flag (sticky until clear)
//  RX_DATA                 in   RX_WIDTH  IOD deserialised data
//  DELAY_LINE_LOAD         out  1         1-cycle pulse: reload static delay (tap 0)
//  DELAY_LINE_MOVE         out  1         1-cycle pulse: step delay one tap
//  DELAY_LINE_DIRECTION    out  1         held 1 (increment) whenever MOVE pulses
//  EYE_MONITOR_CLEAR_FLAGS out  1         1-cycle pulse: clear eye-monitor flags
//  RX_BIT_SLIP             out  1         1-cycle pulse: slip deserialiser one bit
//  BUSY                    out  1         high from start accept until DONE/ERR
//  TRAIN_DONE              out  1         level; alignment succeeded
//  TRAIN_ERR               out  1         level; eye too narrow or slip limit hit
//  TAP_CENTER              out  8         chosen tap (valid with DONE)
//  EYE_WIDTH               out  9         widest clean-window width in taps
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE; reset mid-operation aborts; no pulse issued that cycle.
//  States: IDLE -> LOAD -> CLEAR -> SETTLE -> SAMPLE -> EVAL -> (STEP->CLEAR | CENTER)
//    CENTER -> (ERR | PARK_LOAD -> PARK_MOVE/PARK_SETTLE xTAP_CENTER -> CHECK)
//    CHECK -> (DONE | SLIP -> SETTLE -> CHECK | ERR).
//  Start accepted only when TRAIN_START=1 in IDLE, DONE or ERR; clears DONE/ERR/TAP/WIDTH.
//    Ignored while BUSY.
//  Per tap: CLEAR pulse (1), SETTLE_CYCLES, SAMPLE_CYCLES, EVAL (1), STEP (1).
//    Tap fails if EARLY|LATE seen on any SAMPLE cycle.
//  Window tracker: run of consecutive passing taps; a run still open at TAP_MAX closes at EVAL.
//    Longest run wins; ties keep the earliest (lowest start tap).
//  CENTER: TAP_CENTER = best_start + (best_len>>1), 8-bit.
//    best_len < MIN_EYE -> TRAIN_ERR, TAP_CENTER=0.
//  Parking: one LOAD pulse, then TAP_CENTER MOVE pulses, each followed by SETTLE_CYCLES.
//    No pulse overlaps another.
//  CHECK: RX_DATA must equal TRAIN_PATTERN on every SAMPLE cycle -> DONE.
//    Otherwise RX_BIT_SLIP pulse, settle, recheck.
//  Slip limit: after 2*RX_WIDTH-1 slips without match -> TRAIN_ERR.
//  DONE/ERR hold until next accepted start or reset. BUSY=0 in IDLE/DONE/ERR.
// STRUCTURE
//  Package iod_rx_train_pkg: state enum, pulse-type constants, default TRAIN_PATTERN.
//  Sub-module iod_eye_window_tracker: pass/fail per tap in, best_start/best_len out.
//  FSM plus settle/sample/slip counters stay in this module.
// TESTING
//  1 Eye model passes taps 20..59 -> EYE_WIDTH=40, TAP_CENTER=40, 1 LOAD + 40 parking MOVEs, DONE.
//  2 Passing runs 10..19 and 30..39 -> tie keeps first: TAP_CENTER=15, EYE_WIDTH=10.
//  3 Passing run 100..127 (open at TAP_MAX) -> EYE_WIDTH=28, TAP_CENTER=114.
//  4 Passing taps 50..52 only -> TRAIN_ERR=1, TAP_CENTER=0, no RX_BIT_SLIP.
//  5 Data rotated 2 bits from 4'b1100 -> exactly 2 RX_BIT_SLIP pulses, then DONE.
//    Never-matching data -> 7 slips, then ERR.
//  6 SYNC_RST_N low mid-sweep (tap 33) -> next cycle all outputs 0, IDLE.
//    TRAIN_START while BUSY -> no restart.

Source files
------------

// File: rtl/iod_rx_train_pkg.sv
// Shared types and constants for the RX IOD eye-training controller.
// Holds the FSM state enum, pulse-vector bit positions and the default training word.
package iod_rx_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP,
    ST_CENTER,
    ST_PARK_LOAD,
    ST_PARK_MOVE,
    ST_PARK_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_SLIP_SETTLE,
    ST_DONE,
    ST_ERR
  } train_state_e;

  // Bit positions inside the one-hot pulse request vector.
  localparam int PULSE_W     = 4;
  localparam int PULSE_LOAD  = 0;
  localparam int PULSE_MOVE  = 1;
  localparam int PULSE_CLEAR = 2;
  localparam int PULSE_SLIP  = 3;

  localparam logic [3:0] DEFAULT_TRAIN_PATTERN = 4'b1100;

endpackage

// File: rtl/iod_eye_window_tracker.sv
// Tracks runs of consecutive passing delay taps and keeps the longest one.
// Ties keep the earliest run; a run still open on the last tap closes on that tap.
module iod_eye_window_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       tap_valid,
  input  logic       tap_pass,
  input  logic       tap_last,
  input  logic [7:0] tap_idx,
  output logic [7:0] best_start,
  output logic [8:0] best_len
);

  logic [7:0] run_start;
  logic [8:0] run_len;
  logic [7:0] cand_start;
  logic [8:0] cand_len;
  logic       run_closes;

  always_comb begin
    cand_start = run_start;
    cand_len   = run_len;
    if (tap_pass) begin
      if (run_len == '0) cand_start = tap_idx;
      cand_len = run_len + 9'd1;
    end
    run_closes = !tap_pass || tap_last;
  end

  // Strictly-greater comparison is what keeps the lowest-start run on ties.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (tap_valid) begin
      if (run_closes && (cand_len > best_len)) begin
        best_start <= cand_start;
        best_len   <= cand_len;
      end
      run_start <= cand_start;
      run_len   <= run_closes ? '0 : cand_len;
    end
  end

endmodule

// File: rtl/iod_rx_eye_train_ctrl.sv
// RX IOD lane training: sweeps the delay line scoring taps from the eye monitor,
// parks at the centre of the widest clean window, then bit-slips onto the training word.
module iod_rx_eye_train_ctrl
  import iod_rx_train_pkg::*;
#(
  parameter int RX_WIDTH      = 4,
  parameter int TAP_MAX       = 127,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 32,
  parameter int MIN_EYE       = 4,
  parameter logic [RX_WIDTH-1:0] TRAIN_PATTERN = RX_WIDTH'(DEFAULT_TRAIN_PATTERN)
) (
  input  logic                FAB_CLK,
  input  logic                SYNC_RST_N,
  input  logic                TRAIN_START,
  input  logic                EYE_MONITOR_EARLY,
  input  logic                EYE_MONITOR_LATE,
  input  logic [RX_WIDTH-1:0] RX_DATA,
  output logic                DELAY_LINE_LOAD,
  output logic                DELAY_LINE_MOVE,
  output logic                DELAY_LINE_DIRECTION,
  output logic                EYE_MONITOR_CLEAR_FLAGS,
  output logic                RX_BIT_SLIP,
  output logic                BUSY,
  output logic                TRAIN_DONE,
  output logic                TRAIN_ERR,
  output logic [7:0]          TAP_CENTER,
  output logic [8:0]          EYE_WIDTH
);

  localparam int               CNT_W       = 16;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]       TAP_LAST    = 8'(TAP_MAX);
  localparam logic [7:0]       SLIP_LIMIT  = 8'(2 * RX_WIDTH - 1);
  localparam logic [8:0]       MIN_EYE_W   = 9'(MIN_EYE);

  train_state_e       state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         tap, park_cnt, slip_cnt;
  logic               tap_fail, check_bad;
  logic [7:0]         best_start, center_calc;
  logic [8:0]         best_len;
  logic [PULSE_W-1:0] pulse_next;
  logic               start_ok, data_bad;

  iod_eye_window_tracker u_tracker (
    .clk        (FAB_CLK),
    .rst_n      (SYNC_RST_N),
    .clear      (start_ok),
    .tap_valid  (state == ST_EVAL),
    .tap_pass   (!tap_fail),
    .tap_last   (tap == TAP_LAST),
    .tap_idx    (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_comb begin
    next_state  = state;
    pulse_next  = '0;
    start_ok    = TRAIN_START && (state inside {ST_IDLE, ST_DONE, ST_ERR});
    data_bad    = check_bad || (RX_DATA != TRAIN_PATTERN);
    center_calc = best_start + best_len[8:1];
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start_ok) next_state = ST_LOAD;
      ST_LOAD:        next_state = ST_CLEAR;
      ST_CLEAR:       next_state = ST_SETTLE;
      ST_SETTLE:      if (cnt == SETTLE_LAST) next_state = ST_SAMPLE;
      ST_SAMPLE:      if (cnt == SAMPLE_LAST) next_state = ST_EVAL;
      ST_EVAL:        next_state = (tap == TAP_LAST) ? ST_CENTER : ST_STEP;
      ST_STEP:        next_state = ST_CLEAR;
      ST_CENTER:      next_state = (best_len < MIN_EYE_W) ? ST_ERR : ST_PARK_LOAD;
      ST_PARK_LOAD:   next_state = ST_PARK_SETTLE;
      ST_PARK_MOVE:   next_state = ST_PARK_SETTLE;
      ST_PARK_SETTLE: begin
        if (cnt == SETTLE_LAST)
          next_state = (park_cnt == TAP_CENTER) ? ST_CHECK : ST_PARK_MOVE;
      end
      // The final sample cycle is folded into the verdict through data_bad.
      ST_CHECK: begin
        if (cnt == SAMPLE_LAST) begin
          if (!data_bad)                  next_state = ST_DONE;
          else if (slip_cnt == SLIP_LIMIT) next_state = ST_ERR;
          else                             next_state = ST_SLIP;
        end
      end
      ST_SLIP:        next_state = ST_SLIP_SETTLE;
      ST_SLIP_SETTLE: if (cnt == SETTLE_LAST) next_state = ST_CHECK;
      default:        next_state = ST_IDLE;
    endcase
    case (next_state)
      ST_LOAD, ST_PARK_LOAD: pulse_next[PULSE_LOAD]  = 1'b1;
      ST_STEP, ST_PARK_MOVE: pulse_next[PULSE_MOVE]  = 1'b1;
      ST_CLEAR:              pulse_next[PULSE_CLEAR] = 1'b1;
      ST_SLIP:               pulse_next[PULSE_SLIP]  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (!SYNC_RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tap       <= '0;
      park_cnt  <= '0;
      slip_cnt  <= '0;
      tap_fail  <= 1'b0;
      check_bad <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
      if (state == ST_LOAD)      tap <= '0;
      else if (state == ST_STEP) tap <= tap + 8'd1;
      if (state == ST_CLEAR) tap_fail <= 1'b0;
      else if ((state == ST_SAMPLE) && (EYE_MONITOR_EARLY || EYE_MONITOR_LATE)) tap_fail <= 1'b1;
      if (state == ST_PARK_LOAD)      park_cnt <= '0;
      else if (state == ST_PARK_MOVE) park_cnt <= park_cnt + 8'd1;
      if (start_ok)              slip_cnt <= '0;
      else if (state == ST_SLIP) slip_cnt <= slip_cnt + 8'd1;
      if (state != ST_CHECK)                check_bad <= 1'b0;
      else if (RX_DATA != TRAIN_PATTERN)    check_bad <= 1'b1;
    end
  end

  // Outputs are registered from next_state so a reset cycle never emits a pulse.
  always_ff @(posedge FAB_CLK) begin
    if (!SYNC_RST_N) begin
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      RX_BIT_SLIP             <= 1'b0;
      BUSY                    <= 1'b0;
      TRAIN_DONE              <= 1'b0;
      TRAIN_ERR               <= 1'b0;
      TAP_CENTER              <= '0;
      EYE_WIDTH               <= '0;
    end else begin
      DELAY_LINE_LOAD         <= pulse_next[PULSE_LOAD];
      DELAY_LINE_MOVE         <= pulse_next[PULSE_MOVE];
      DELAY_LINE_DIRECTION    <= pulse_next[PULSE_MOVE];
      EYE_MONITOR_CLEAR_FLAGS <= pulse_next[PULSE_CLEAR];
      RX_BIT_SLIP             <= pulse_next[PULSE_SLIP];
      BUSY                    <= !(next_state inside {ST_IDLE, ST_DONE, ST_ERR});
      TRAIN_DONE              <= (next_state == ST_DONE);
      TRAIN_ERR               <= (next_state == ST_ERR);
      if (start_ok) begin
        TAP_CENTER <= '0;
        EYE_WIDTH  <= '0;
      end else if (state == ST_CENTER) begin
        EYE_WIDTH  <= best_len;
        TAP_CENTER <= (best_len < MIN_EYE_W) ? '0 : center_calc;
      end
    end
  end

endmodule

// File: tb/tb_iod_rx_eye_train_ctrl.sv
// Bench for iod_rx_eye_train_ctrl: IOD lane model (delay line, sticky eye flags,
// bit-slipping deserialiser) plus a window-search reference computed from the eye mask.
module tb_iod_rx_eye_train_ctrl;

  localparam int         W         = 4;
  localparam int         TAP_MAX   = 127;
  localparam int         SETTLE    = 3;
  localparam int         SAMPLE    = 4;
  localparam int         MIN_EYE   = 4;
  localparam logic [W-1:0] PATTERN = 4'b1100;
  localparam int         IDLE_WAIT = 6000;

  logic         FAB_CLK;
  logic         SYNC_RST_N;
  logic         TRAIN_START;
  logic         early_q, late_q;
  logic [W-1:0] rx_data;
  logic         DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
  logic         EYE_MONITOR_CLEAR_FLAGS, RX_BIT_SLIP, BUSY, TRAIN_DONE, TRAIN_ERR;
  logic [7:0]   TAP_CENTER;
  logic [8:0]   EYE_WIDTH;

  bit [255:0]   eye_mask;
  bit           rx_never;
  int           rot_init;
  logic [7:0]   model_tap;
  int           load_total, slip_total, viol_total, moves_after_load;
  int           load_base, slip_base, viol_base;
  int           checks, errors;

  iod_rx_eye_train_ctrl #(
    .RX_WIDTH      (W),
    .TAP_MAX       (TAP_MAX),
    .SETTLE_CYCLES (SETTLE),
    .SAMPLE_CYCLES (SAMPLE),
    .MIN_EYE       (MIN_EYE),
    .TRAIN_PATTERN (PATTERN)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .SYNC_RST_N              (SYNC_RST_N),
    .TRAIN_START             (TRAIN_START),
    .EYE_MONITOR_EARLY       (early_q),
    .EYE_MONITOR_LATE        (late_q),
    .RX_DATA                 (rx_data),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .RX_BIT_SLIP             (RX_BIT_SLIP),
    .BUSY                    (BUSY),
    .TRAIN_DONE              (TRAIN_DONE),
    .TRAIN_ERR               (TRAIN_ERR),
    .TAP_CENTER              (TAP_CENTER),
    .EYE_WIDTH               (EYE_WIDTH)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] p, input int r);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < W; i++) o[(i + r) % W] = p[i];
    return o;
  endfunction

  // Deserialiser: each slip advances the rotation by one; rot 0 is the aligned word.
  always_comb begin
    rx_data = rx_never ? 4'b0101 : rotl(PATTERN, (rot_init + slip_total - slip_base) % W);
  end

  // IOD delay line and sticky eye monitor; a failing tap randomly raises EARLY or LATE.
  always @(posedge FAB_CLK) begin
    if (DELAY_LINE_LOAD) begin
      model_tap        <= 8'd0;
      moves_after_load <= 0;
    end else if (DELAY_LINE_MOVE) begin
      model_tap        <= model_tap + 8'd1;
      moves_after_load <= moves_after_load + 1;
    end
    if (EYE_MONITOR_CLEAR_FLAGS) begin
      early_q <= 1'b0;
      late_q  <= 1'b0;
    end else if (!eye_mask[model_tap]) begin
      if ($urandom_range(0, 1) == 1) early_q <= 1'b1;
      else                           late_q  <= 1'b1;
    end
    if (DELAY_LINE_LOAD) load_total <= load_total + 1;
    if (RX_BIT_SLIP)     slip_total <= slip_total + 1;
    if (($countones({DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS, RX_BIT_SLIP}) > 1)
        || (DELAY_LINE_MOVE && !DELAY_LINE_DIRECTION))
      viol_total <= viol_total + 1;
  end

  initial begin
    model_tap = 8'd0; early_q = 1'b0; late_q = 1'b0;
    load_total = 0; slip_total = 0; viol_total = 0; moves_after_load = 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic bit [255:0] runMask(input int lo, input int hi);
    bit [255:0] m;
    m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Reference: longest run of passing taps over 0..TAP_MAX, earliest wins ties.
  task automatic refEye(input bit [255:0] m, output int bstart, output int blen);
    int run, rs;
    run = 0; rs = 0; bstart = 0; blen = 0;
    for (int t = 0; t <= TAP_MAX; t++) begin
      if (m[t]) begin
        if (run == 0) rs = t;
        run++;
        if (run > blen) begin
          blen   = run;
          bstart = rs;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic startTraining(input string tag, input bit [255:0] m, input bit never, input int rot);
    eye_mask  = m;
    rx_never  = never;
    rot_init  = rot;
    @(negedge FAB_CLK);
    load_base   = load_total;
    slip_base   = slip_total;
    viol_base   = viol_total;
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    checkOutput({tag, "_busy_on_start"}, BUSY, 1);
    checkOutput({tag, "_start_clears"}, {TRAIN_DONE, TRAIN_ERR, TAP_CENTER, EYE_WIDTH}, 0);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (BUSY && (n < IDLE_WAIT)) begin
      @(negedge FAB_CLK);
      n++;
    end
    checkOutput({tag, "_timeout"}, (n >= IDLE_WAIT), 0);
  endtask

  task automatic applyStimulus(input string tag, input bit [255:0] m, input bit never, input int rot);
    startTraining(tag, m, never, rot);
    waitIdle(tag);
  endtask

  task automatic expectResult(input string tag);
    int  bs, bl, center, slips;
    bit  eye_ok;
    refEye(eye_mask, bs, bl);
    eye_ok = (bl >= MIN_EYE);
    center = eye_ok ? ((bs + bl / 2) % 256) : 0;
    slips  = !eye_ok ? 0 : (rx_never ? (2 * W - 1) : ((W - rot_init) % W));
    checkOutput({tag, "_done"}, TRAIN_DONE, (eye_ok && !rx_never));
    checkOutput({tag, "_err"}, TRAIN_ERR, (!eye_ok || rx_never));
    checkOutput({tag, "_width"}, EYE_WIDTH, bl);
    if (!(eye_ok && rx_never)) checkOutput({tag, "_center"}, TAP_CENTER, center);
    checkOutput({tag, "_loads"}, load_total - load_base, eye_ok ? 2 : 1);
    checkOutput({tag, "_moves_after_load"}, moves_after_load, eye_ok ? center : TAP_MAX);
    checkOutput({tag, "_slips"}, slip_total - slip_base, slips);
    checkOutput({tag, "_pulse_protocol"}, viol_total - viol_base, 0);
  endtask

  initial begin
    int n, snap;
    bit [255:0] m;
    checks = 0; errors = 0;
    eye_mask = '0; rx_never = 1'b0; rot_init = 0;
    load_base = 0; slip_base = 0; viol_base = 0;
    SYNC_RST_N = 1'b0; TRAIN_START = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    checkOutput("reset_outputs",
                {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
                 RX_BIT_SLIP, BUSY, TRAIN_DONE, TRAIN_ERR, TAP_CENTER, EYE_WIDTH}, 0);
    SYNC_RST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    $display("[TB] single eye 20..59");
    applyStimulus("eye20_59", runMask(20, 59), 1'b0, 0);
    expectResult("eye20_59");

    $display("[TB] tied windows 10..19 / 30..39");
    applyStimulus("tie", runMask(10, 19) | runMask(30, 39), 1'b0, $urandom_range(0, W - 1));
    expectResult("tie");

    $display("[TB] window open at last tap");
    applyStimulus("open_end", runMask(100, 127), 1'b0, $urandom_range(0, W - 1));
    expectResult("open_end");

    $display("[TB] eye too narrow");
    applyStimulus("narrow", runMask(50, 52), 1'b0, 0);
    expectResult("narrow");

    $display("[TB] data rotated by two");
    applyStimulus("rot2", runMask(20, 59), 1'b0, 2);
    expectResult("rot2");

    $display("[TB] data never matches");
    applyStimulus("nomatch", runMask(20, 59), 1'b1, 0);
    expectResult("nomatch");

    $display("[TB] reset mid-sweep");
    startTraining("rst", runMask(20, 59), 1'b0, 0);
    n = 0;
    while ((model_tap != 8'd33) && (n < 2000)) begin
      @(negedge FAB_CLK);
      n++;
    end
    checkOutput("rst_reach_tap33_timeout", (n >= 2000), 0);
    SYNC_RST_N = 1'b0;
    @(posedge FAB_CLK);
    #1;
    checkOutput("rst_outputs_cleared",
                {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
                 RX_BIT_SLIP, BUSY, TRAIN_DONE, TRAIN_ERR, TAP_CENTER, EYE_WIDTH}, 0);
    @(negedge FAB_CLK);
    SYNC_RST_N = 1'b1;
    snap = load_total;
    repeat (5) @(negedge FAB_CLK);
    checkOutput("rst_stays_idle", {BUSY, TRAIN_DONE, TRAIN_ERR}, 0);
    checkOutput("rst_no_new_load", load_total - snap, 0);

    $display("[TB] start while busy");
    startTraining("busy_start", runMask(30, 80), 1'b0, 1);
    n = 0;
    while ((model_tap != 8'd5) && (n < 2000)) begin
      @(negedge FAB_CLK);
      n++;
    end
    checkOutput("busy_start_reach_timeout", (n >= 2000), 0);
    snap = load_total;
    TRAIN_START = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    TRAIN_START = 1'b0;
    repeat (10) @(negedge FAB_CLK);
    checkOutput("busy_start_ignored", load_total - snap, 0);
    waitIdle("busy_start");
    expectResult("busy_start");

    for (int k = 0; k < 3; k++) begin
      m = '0;
      for (int r = 0; r < 3; r++) begin
        n = $urandom_range(0, 120);
        m = m | runMask(n, ((n + $urandom_range(0, 30)) > TAP_MAX) ? TAP_MAX : (n + $urandom_range(0, 30)));
      end
      $display("[TB] random eye %0d", k);
      applyStimulus("random", m, 1'b0, $urandom_range(0, W - 1));
      expectResult("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
